// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a length-prefixed byte stream and writes it into
// instruction memory as 32-bit words, holding the cpu in reset until the image
// is loaded. Stream format: LEN_HI, LEN_LO (word count), then words MSB first.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte (S_CHK) that must match the XOR of all data bytes.
module imem_boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic        load_req,
    output logic        imem_wren,
    output logic [31:0] imem_waddr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst,
    output logic        done,
    output logic        error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    localparam logic [31:0] MAXW = 32'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_INIT, S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] len_q;
    logic [15:0] idx_q;
    logic [1:0]  bcnt_q;
    logic [23:0] sh_q;
    logic [7:0]  csum_q;
    logic        fin_q;     // last word written, leave S_DATA next cycle
    logic        ovf_q;     // at least one word fell beyond MAX_WORDS
    logic        wren_q;
    logic [31:0] waddr_q;
    logic [31:0] wdata_q;

    logic xfer, word_end, last_word, zero_len, restart, in_range;

    // While the final write drains (fin_q) no further byte is taken, so any
    // trailing garbage stays with the source.
    assign byte_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                        ((state_q == S_DATA) && !fin_q) || (state_q == S_CHK);
    assign xfer      = byte_valid & byte_ready;
    assign word_end  = (state_q == S_DATA) && xfer && (bcnt_q == 2'd3);
    assign last_word = (idx_q + 16'd1) == len_q;
    assign zero_len  = ({len_q[15:8], byte_data} == 16'd0);
    assign restart   = load_req && ((state_q == S_DONE) || (state_q == S_ERR));
    assign in_range  = ({16'd0, idx_q} < MAXW);

    assign imem_wren  = wren_q;
    assign imem_waddr = waddr_q;
    assign imem_wdata = wdata_q;
    assign done       = (state_q == S_DONE);
    assign cpu_rst    = (state_q != S_DONE);
    assign error      = (state_q == S_ERR);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_INIT;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:   state_d = S_LEN_HI;
            S_LEN_HI: if (xfer) state_d = S_LEN_LO;
            S_LEN_LO: if (xfer) state_d = (zero_len && CHK_EN) ? S_CHK : S_DATA;
            S_DATA: begin
                if (fin_q)
                    state_d = ovf_q ? S_ERR : S_DONE;
                else if (word_end && last_word && CHK_EN)
                    state_d = S_CHK;
            end
            S_CHK:    if (xfer) state_d = (ovf_q || (byte_data != csum_q)) ? S_ERR : S_DONE;
            S_DONE,
            S_ERR:    if (load_req) state_d = S_LEN_HI;
            default:  state_d = S_INIT;
        endcase
    end

    // Length capture, word assembly, memory write strobe and checksum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q   <= 16'd0;
            idx_q   <= 16'd0;
            bcnt_q  <= 2'd0;
            sh_q    <= 24'd0;
            csum_q  <= 8'd0;
            fin_q   <= 1'b0;
            ovf_q   <= 1'b0;
            wren_q  <= 1'b0;
            waddr_q <= BASE_ADDR;
            wdata_q <= 32'd0;
        end else begin
            wren_q <= 1'b0;
            if (restart) begin
                idx_q  <= 16'd0;
                bcnt_q <= 2'd0;
                csum_q <= 8'd0;
                fin_q  <= 1'b0;
                ovf_q  <= 1'b0;
            end
            if ((state_q == S_LEN_HI) && xfer)
                len_q[15:8] <= byte_data;
            if ((state_q == S_LEN_LO) && xfer) begin
                len_q[7:0] <= byte_data;
                // Empty image without checksum: finish through the same drain
                // cycle a data image uses.
                fin_q <= zero_len && !CHK_EN;
            end
            if ((state_q == S_DATA) && fin_q)
                fin_q <= 1'b0;
            if ((state_q == S_DATA) && xfer) begin
                csum_q <= csum_q ^ byte_data;
                bcnt_q <= bcnt_q + 2'd1;
                sh_q   <= {sh_q[15:0], byte_data};
                if (bcnt_q == 2'd3) begin
                    idx_q <= idx_q + 16'd1;
                    if (in_range) begin
                        wren_q  <= 1'b1;
                        waddr_q <= BASE_ADDR + {14'd0, idx_q, 2'b00};
                        wdata_q <= {sh_q, byte_data};
                    end else begin
                        ovf_q <= 1'b1;
                    end
                    if (last_word && !CHK_EN)
                        fin_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed scenarios plus randomized
// images, compared against a word-list reference model of the stream format.
module tb_imem_boot_loader;

    localparam int MAXW = 2;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit TB_CHK = 1'b1;
`else
    localparam bit TB_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        load_req;
    logic        imem_wren;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        error;

    imem_boot_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .load_req(load_req), .imem_wren(imem_wren),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .cpu_rst(cpu_rst),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // observed writes
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    always @(negedge clk) begin
        if (imem_wren === 1'b1) begin
            wa_q.push_back(imem_waddr);
            wd_q.push_back(imem_wdata);
            wc_q.push_back(cyc);
        end
    end

    // expected writes (reference model)
    logic [31:0] ea_q[$];
    logic [31:0] ed_q[$];
    int          ec_q[$];
    logic [31:0] img[$];
    logic [7:0]  csum_m;
    int          last_acc;
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic int gap_of(input int gm);
        if (gm == 1) return 1;
        if (gm == 2) return int'($urandom_range(0, 2));
        return 0;
    endfunction

    // Present one byte and wait until it is accepted; entered at posedge+1.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        byte_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        byte_valid = 1'b1;
        byte_data  = b;
        t = 0;
        forever begin
            @(negedge clk);
            if (byte_ready === 1'b1) break;
            t++;
            if (t > 50) begin
                n_cmp++; n_err++;
                $display("FAIL send_timeout: byte %h not accepted, ready=%b", b, byte_ready);
                byte_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        last_acc   = cyc;
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
    endtask

    task automatic send_image(input int gm, input bit bad);
        logic [15:0] n;
        logic [31:0] w;
        logic [7:0]  b;
        n = 16'(img.size());
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        ea_q.delete(); ed_q.delete(); ec_q.delete();
        csum_m = 8'd0;
        send_byte(n[15:8], gap_of(gm));
        send_byte(n[7:0], gap_of(gm));
        for (int i = 0; i < img.size(); i++) begin
            w = img[i];
            for (int j = 0; j < 4; j++) begin
                b = w[31 - 8*j -: 8];
                csum_m ^= b;
                send_byte(b, gap_of(gm));
                if (j == 3 && i < MAXW) begin
                    ea_q.push_back(32'(i) * 32'd4);
                    ed_q.push_back(w);
                    ec_q.push_back(last_acc);
                end
            end
        end
        if (TB_CHK) send_byte(bad ? (csum_m ^ 8'h01) : csum_m, gap_of(gm));
    endtask

    task automatic check_image(input string name, input bit bad);
        bit exp_err;
        exp_err = (img.size() > MAXW) || (TB_CHK && bad);
        @(negedge clk);
        if (!TB_CHK) begin
            n_cmp++;
            if (done !== 1'b0 || cpu_rst !== 1'b1) begin
                n_err++;
                $display("FAIL %s early_done: done=%b cpu_rst=%b want 0/1", name, done, cpu_rst);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (done !== !exp_err || error !== exp_err || cpu_rst !== exp_err || byte_ready !== 1'b0) begin
            n_err++;
            $display("FAIL %s final: done=%b error=%b cpu_rst=%b ready=%b want %b/%b/%b/0",
                     name, done, error, cpu_rst, byte_ready, !exp_err, exp_err, exp_err);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (wa_q.size() != ea_q.size()) begin
            n_err++;
            $display("FAIL %s write_count: got %0d want %0d", name, wa_q.size(), ea_q.size());
        end else begin
            for (int i = 0; i < ea_q.size(); i++) begin
                n_cmp++;
                if (wa_q[i] !== ea_q[i] || wd_q[i] !== ed_q[i] || wc_q[i] != ec_q[i]) begin
                    n_err++;
                    $display("FAIL %s write%0d: addr=%h data=%h cyc=%0d want %h/%h/%0d",
                             name, i, wa_q[i], wd_q[i], wc_q[i], ea_q[i], ed_q[i], ec_q[i]);
                end
            end
        end
    endtask

    task automatic restart();
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; load_req = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (byte_ready !== 1'b0 || imem_wren !== 1'b0 || imem_waddr !== 32'h0 || imem_wdata !== 32'h0 ||
            cpu_rst !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
            n_err++;
            $display("FAIL reset_values: ready=%b wren=%b waddr=%h wdata=%h cpu_rst=%b done=%b error=%b",
                     byte_ready, imem_wren, imem_waddr, imem_wdata, cpu_rst, done, error);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (byte_ready !== 1'b0) begin
            n_err++;
            $display("FAIL init_ready: got %b want 0", byte_ready);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (byte_ready !== 1'b1) begin
            n_err++;
            $display("FAIL len_hi_ready: got %b want 1", byte_ready);
        end
    endtask

    task automatic test_basic();
        img = '{32'h2008_0005, 32'h0000_0000};
        send_image(0, 1'b0);
        check_image("basic", 1'b0);
    endtask

    task automatic test_zero_len();
        restart();
        img.delete();
        send_image(0, 1'b0);
        check_image("zero_len", 1'b0);
    endtask

    task automatic test_overflow();
        restart();
        img = '{32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'hAAAA_AAAA};
        send_image(0, 1'b0);
        check_image("overflow", 1'b0);
    endtask

    task automatic test_toggle();
        restart();
        img = '{32'h2008_0005, 32'h0000_0000};
        send_image(1, 1'b0);
        check_image("toggle", 1'b0);
    endtask

    task automatic test_load_req();
        // idle in S_DONE with a byte on offer: nothing taken, nothing written
        wa_q.delete();
        byte_valid = 1'b1; byte_data = 8'h5A;
        repeat (3) @(posedge clk);
        #1;
        byte_valid = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || byte_ready !== 1'b0 || wa_q.size() != 0) begin
            n_err++;
            $display("FAIL done_idle: done=%b ready=%b writes=%0d want 1/0/0", done, byte_ready, wa_q.size());
        end
        restart();
        n_cmp++;
        if (done !== 1'b0 || error !== 1'b0 || cpu_rst !== 1'b1 || byte_ready !== 1'b1) begin
            n_err++;
            $display("FAIL load_req: done=%b error=%b cpu_rst=%b ready=%b want 0/0/1/1",
                     done, error, cpu_rst, byte_ready);
        end
    endtask

    task automatic test_rst_mid();
        // entered in S_LEN_HI
        wa_q.delete();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (cpu_rst !== 1'b1 || byte_ready !== 1'b0 || imem_wren !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid: cpu_rst=%b ready=%b wren=%b done=%b want 1/0/0/0",
                     cpu_rst, byte_ready, imem_wren, done);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (wa_q.size() != 0) begin
            n_err++;
            $display("FAIL rst_mid_writes: got %0d want 0", wa_q.size());
        end
        img = '{32'h1234_5678};
        send_image(0, 1'b0);
        check_image("reload", 1'b0);
    endtask

    task automatic test_checksum();
        restart();
        img = '{32'h0102_0304};
        send_image(0, 1'b0);
        check_image("chk_good", 1'b0);
        restart();
        send_image(0, 1'b1);
        check_image("chk_bad", 1'b1);
        restart();
        send_image(2, 1'b0);
        check_image("chk_again", 1'b0);
    endtask

    task automatic test_random();
        int  n;
        int  gm;
        bit  bad;
        for (int it = 0; it < 10; it++) begin
            restart();
            n = int'($urandom_range(0, 4));
            img.delete();
            for (int i = 0; i < n; i++) img.push_back($urandom);
            gm  = int'($urandom_range(0, 2));
            bad = TB_CHK ? 1'($urandom_range(0, 1)) : 1'b0;
            send_image(gm, bad);
            check_image($sformatf("random%0d", it), bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_load_req();
        test_zero_len();
        test_overflow();
        test_toggle();
        restart();
        test_rst_mid();
        if (TB_CHK) test_checksum();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: run did not complete");
        $fatal(1, "timeout");
    end

endmodule
